// File: rtl/shiyan_pkg.sv
// Shared defaults and helpers for the modulo up/down counter.
package shiyan_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_MOD    = 16;
  localparam int unsigned DEF_WRAP_W = 8;

  // True when the count sits at the end of its range for the given direction.
  function automatic logic at_terminal(input int unsigned q,
                                       input logic        up,
                                       input int unsigned modulus);
    return up ? (q == modulus - 1) : (q == 0);
  endfunction

endpackage

// File: rtl/mod_updn_counter_wrap_sat.sv
// Saturating event counter: counts wrap events and sticks at all-ones.
module wrap_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mod_updn_counter.sv
// Modulo-MOD up/down counter with parallel load, cascade carry,
// one-shot mode and a saturating count of wrap events.
module mod_updn_counter
  import shiyan_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MOD    = DEF_MOD,
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              mr,
  input  logic              load,
  input  logic              en,
  input  logic              ci,
  input  logic              up_dn,
  input  logic              stop,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              co,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  // Reject a modulus the counter width cannot represent.
  if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH))) begin : g_bad_mod
    $error("mod_updn_counter: MOD must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_val;
  logic             step;
  logic             at_term;
  logic             wrap_inc;
  logic             wrap_clr;

  // Out-of-range load values clamp to the top of the count range.
  assign load_val = (32'(d) >= MOD) ? MAX_Q : d;

  // A step needs no load, enable, carry-in, and a counter not yet finished.
  assign step    = load & en & ci & ~done_q;
  assign at_term = at_terminal(32'(q_q), up_dn, MOD);

  // Carry/borrow out is purely combinational so a following stage can use it
  // as ci in the same cycle; mr gating keeps it low throughout reset.
  assign co = mr & step & at_term;

  // Next count and done flag: load first, then count, else hold.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    q_d      = q_q;
    done_d   = done_q;
    wrap_inc = 1'b0;
    wrap_clr = 1'b0;
    if (!load) begin
      q_d      = load_val;
      done_d   = 1'b0;
      wrap_clr = 1'b1;
    end else if (step) begin
      if (at_term) begin
        if (stop) begin
          done_d = 1'b1;
        end else begin
          q_d      = up_dn ? '0 : MAX_Q;
          wrap_inc = 1'b1;
        end
      end else begin
        q_d = up_dn ? (q_q + 1'b1) : (q_q - 1'b1);
      end
    end
  end

  // Count and completion registers.
  always_ff @(posedge clk or negedge mr) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!mr) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  wrap_sat_counter #(
    .W (WRAP_W)
  ) u_wrap_sat_counter (
    .clk   (clk),
    .rst_n (mr),
    .clr   (wrap_clr),
    .inc   (wrap_inc),
    .cnt   (wraps)
  );

  assign q    = q_q;
  assign done = done_q;

endmodule
